fragment_lane_packer: RTL and testbench
=======================================

# fragment_lane_packer

Packs the 32-bit fragment beats emitted on the rasterization2 stage's LII output, one fragment per PW-bit beat, into full PW-bit beats carrying PW/FW fragments each. It sits directly downstream of the rasterization2 wrapper and feeds the LII link toward the z-culling stage, cutting link beats by up to LANES×. Partial words are flushed on an idle timeout or on a change of the src/dst route.

## Interface
Parameters:
- PW, 128, LII packing width.
- FW, 32, fragment width; fragment occupies in_tdata[FW-1:0].
- LANES, PW/FW (4), fragments per output beat.
- TIMEOUT, 16, idle cycles before a partial word is flushed (≥1).

Ports:
- aclk  in  1  single clock, all logic rising-edge.
- arstn  in  1  asynchronous active-low reset.
- lii_in_p0_tdata  in  PW  fragment in [FW-1:0]; upper bits ignored.
- lii_in_p0_tvalid  in  1  input valid.
- lii_in_p0_tready  out  1  input ready.
- lii_in_p0_src / lii_in_p0_dst  in  8 each  route sideband of the fragment.
- lii_out_p0_tdata  out  PW  packed fragments, lane i at [i*FW+FW-1 : i*FW].
- lii_out_p0_tkeep  out  LANES  lane-valid mask, contiguous from lane 0.
- lii_out_p0_tvalid  out  1  output valid.
- lii_out_p0_tready  in  1  output ready.
- lii_out_p0_src / lii_out_p0_dst  out  8 each  route of the packed word.

## Operation
- Accumulator: acc[LANES][FW], cnt (0..LANES-1), acc_src/acc_dst latched from the first fragment of a word. Lane cnt written on accept; unused lanes are zero.
- Output register (out_valid, data, keep, src, dst) with standard AXI-S hold: contents stable while tvalid=1 and tready=0.
- out_free = !out_valid | lii_out_p0_tready.
- Fill complete: accepting a fragment when cnt==LANES-1 moves the full word (keep = all ones) into the output register on that edge; cnt→0.
- lii_in_p0_tready = arstn & !mismatch & (cnt<LANES-1 | out_free).
- mismatch = tvalid & cnt>0 & (in_src≠acc_src | in_dst≠acc_dst). On mismatch: no accept; when out_free, flush the partial word (keep = (1<<cnt)-1, src/dst = acc_*), cnt→0; the fragment is accepted the next cycle as lane 0 of a new word.
- Idle counter idle: cleared on any accept or when cnt==0; otherwise increments, saturating at TIMEOUT. When idle==TIMEOUT and out_free: flush partial word as above, idle→0.
- Priority in one cycle: accept > mismatch flush > timeout flush. An accept in the same cycle timeout would fire cancels the timeout.
- Never emits keep==0; never reorders fragments; no fragment dropped or duplicated.

## Timing
- Reset (arstn low, async): out_valid=0, tdata=0, tkeep=0, src=dst=0, cnt=0, idle=0, lii_in_p0_tready=0. First cycle after release: tready=1.
- Full-word latency: lii_out_p0_tvalid rises the cycle after the LANES-th fragment is accepted.
- Throughput: 1 fragment/cycle sustained with tready=1 on output; 1 output beat per LANES cycles.
- Timeout latency: partial word valid TIMEOUT+1 cycles after last accept (output free).
- Back-pressure: with output stalled, input accepts up to LANES-1 more fragments, then tready=0 until output drains; tready combinational in lii_out_p0_tready.
- Reset mid-word: buffered fragments discarded, no output beat.

## Structure
- Package fragment_pack_pkg: FW, LANES, lane-count and keep-mask typedefs, keep_from_cnt function.
- Sub-module lii_out_reg: single-entry output register with load/hold; packer FSM and accumulator in the top.

## Test plan
- 8 fragments 0x11..0x18, same src=1/dst=2, output ready -> two beats, tdata 0x14131211/0x18171615 in lanes, tkeep=0xF, src=1 dst=2, first beat 1 cycle after 4th accept.
- 3 fragments then idle, TIMEOUT=16 -> one beat, tkeep=0x7, lane3=0, valid 17 cycles after last accept.
- Fragments A,B with dst=2 then C with dst=3 -> beat {A,B} keep=0x3 dst=2, C stalled one cycle, then starts new word with dst=3.
- Output tready=0 for 20 cycles, 10 input fragments offered -> exactly 7 accepted (4 in output reg, 3 in acc), tready=0 after, data held stable; release -> order preserved.
- Fragment accepted on the exact cycle idle would reach TIMEOUT -> no partial flush, word continues filling.
- arstn pulsed low with cnt=2 -> all outputs zero immediately, no beat emitted for the 2 fragments, normal packing resumes after release.

Source files
------------

// File: rtl/fragment_pack_pkg.sv
`default_nettype none
// ============================================================================
// fragment_pack_pkg: shared lane/keep types and helpers for the fragment packer
// Revision: 1.0
// ============================================================================
package fragment_pack_pkg;

    localparam int FW        = 32;
    localparam int LANES     = 4;
    localparam int CNT_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int MAX_LANES = 32;

    typedef logic [CNT_W-1:0] lane_cnt_t;
    typedef logic [LANES-1:0] keep_t;

    // Contiguous lane mask covering lanes [0, n); saturates at MAX_LANES.
    function automatic logic [MAX_LANES-1:0] keep_from_cnt(input int unsigned n);
        if (n >= MAX_LANES)
            return '1;
        return (MAX_LANES'(1) << n) - MAX_LANES'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lii_out_reg.sv
`default_nettype none
// ============================================================================
// lii_out_reg: single-entry AXI-S output register with load/hold semantics
// Revision: 1.0
// ============================================================================
module lii_out_reg #(
    parameter int PW    = 128,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             i_load,
    input  logic [PW-1:0]    i_data,
    input  logic [LANES-1:0] i_keep,
    input  logic [7:0]       i_src,
    input  logic [7:0]       i_dst,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [PW-1:0]    o_data,
    output logic [LANES-1:0] o_keep,
    output logic [7:0]       o_src,
    output logic [7:0]       o_dst
);

    logic             r_valid;
    logic [PW-1:0]    r_data;
    logic [LANES-1:0] r_keep;
    logic [7:0]       r_src;
    logic [7:0]       r_dst;

    // The packer only asserts i_load when the register is free, so a held
    // beat is never overwritten.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_src   <= '0;
            r_dst   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_keep  <= i_keep;
            r_src   <= i_src;
            r_dst   <= i_dst;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_src   = r_src;
    assign o_dst   = r_dst;

endmodule
`default_nettype wire

// File: rtl/fragment_lane_packer.sv
`default_nettype none
// ============================================================================
// fragment_lane_packer: packs one-fragment LII beats into PW/FW-lane beats
// Revision: 1.0
// ============================================================================
module fragment_lane_packer #(
    parameter int PW      = 128,
    parameter int FW      = fragment_pack_pkg::FW,
    parameter int LANES   = PW / FW,
    parameter int TIMEOUT = 16
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic [PW-1:0]    lii_in_p0_tdata,
    input  logic             lii_in_p0_tvalid,
    output logic             lii_in_p0_tready,
    input  logic [7:0]       lii_in_p0_src,
    input  logic [7:0]       lii_in_p0_dst,
    output logic [PW-1:0]    lii_out_p0_tdata,
    output logic [LANES-1:0] lii_out_p0_tkeep,
    output logic             lii_out_p0_tvalid,
    input  logic             lii_out_p0_tready,
    output logic [7:0]       lii_out_p0_src,
    output logic [7:0]       lii_out_p0_dst
);

    import fragment_pack_pkg::*;

    localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  c_last_lane = CNT_W'(LANES - 1);
    localparam logic [IDLE_W-1:0] c_timeout   = IDLE_W'(TIMEOUT);

    logic [LANES-1:0][FW-1:0] r_acc;
    logic [CNT_W-1:0]         r_cnt;
    logic [IDLE_W-1:0]        r_idle;
    logic [7:0]               r_src;
    logic [7:0]               r_dst;

    logic                     w_out_free;
    logic                     w_mismatch;
    logic                     w_last;
    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_fill;
    logic                     w_flush;
    logic                     w_load;
    logic [LANES-1:0][FW-1:0] w_fill_word;
    logic [LANES-1:0][FW-1:0] w_ld_word;
    logic [LANES-1:0]         w_ld_keep;
    logic [7:0]               w_ld_src;
    logic [7:0]               w_ld_dst;
    logic [FW-1:0]            w_frag;

    assign w_frag = lii_in_p0_tdata[FW-1:0];

    generate
        if (PW > FW) begin : g_unused_upper
            logic w_unused_upper;
            assign w_unused_upper = ^lii_in_p0_tdata[PW-1:FW];
        end
    endgenerate

    assign w_out_free = !lii_out_p0_tvalid || lii_out_p0_tready;
    assign w_last     = (r_cnt == c_last_lane);
    assign w_mismatch = lii_in_p0_tvalid && (r_cnt != '0) &&
                        ((lii_in_p0_src != r_src) || (lii_in_p0_dst != r_dst));

    // arstn gates ready so nothing is accepted while reset is held.
    assign w_in_ready = arstn && !w_mismatch && (!w_last || w_out_free);
    assign w_accept   = lii_in_p0_tvalid && w_in_ready;
    assign w_fill     = w_accept && w_last;

    // Accept outranks both flush sources; mismatch and timeout flush the same word.
    assign w_flush = !w_accept && w_out_free && (r_cnt != '0) &&
                     (w_mismatch || (r_idle == c_timeout));
    assign w_load  = w_fill || w_flush;

    always_comb begin
        w_fill_word        = r_acc;
        w_fill_word[r_cnt] = w_frag;
    end

    assign w_ld_word = w_fill ? w_fill_word : r_acc;
    assign w_ld_keep = w_fill ? {LANES{1'b1}} : LANES'(keep_from_cnt(32'(r_cnt)));
    assign w_ld_src  = (w_fill && (r_cnt == '0)) ? lii_in_p0_src : r_src;
    assign w_ld_dst  = (w_fill && (r_cnt == '0)) ? lii_in_p0_dst : r_dst;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_idle <= '0;
            r_src  <= '0;
            r_dst  <= '0;
        end else begin
            // Clearing on emission keeps unused lanes of the next partial word zero.
            if (w_load) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_acc[r_cnt] <= w_frag;
                r_cnt        <= r_cnt + 1'b1;
                if (r_cnt == '0) begin
                    r_src <= lii_in_p0_src;
                    r_dst <= lii_in_p0_dst;
                end
            end

            if (w_accept || w_load || (r_cnt == '0))
                r_idle <= '0;
            else if (r_idle != c_timeout)
                r_idle <= r_idle + 1'b1;
        end
    end

    lii_out_reg #(
        .PW    (PW),
        .LANES (LANES)
    ) u_out_reg (
        .clk     (aclk),
        .arstn   (arstn),
        .i_load  (w_load),
        .i_data  (w_ld_word),
        .i_keep  (w_ld_keep),
        .i_src   (w_ld_src),
        .i_dst   (w_ld_dst),
        .i_ready (lii_out_p0_tready),
        .o_valid (lii_out_p0_tvalid),
        .o_data  (lii_out_p0_tdata),
        .o_keep  (lii_out_p0_tkeep),
        .o_src   (lii_out_p0_src),
        .o_dst   (lii_out_p0_dst)
    );

    assign lii_in_p0_tready = w_in_ready;

endmodule
`default_nettype wire

// File: tb/tb_fragment_lane_packer.sv
`default_nettype none
// ============================================================================
// tb_fragment_lane_packer: directed self-checking bench for fragment_lane_packer
// Revision: 1.0
// ============================================================================
module tb_fragment_lane_packer;

    logic         clk = 1'b0;
    logic         arstn = 1'b0;
    logic [127:0] in_tdata;
    logic         in_tvalid;
    logic         in_tready;
    logic [7:0]   in_src;
    logic [7:0]   in_dst;
    logic [127:0] out_tdata;
    logic [3:0]   out_tkeep;
    logic         out_tvalid;
    logic         out_tready;
    logic [7:0]   out_src;
    logic [7:0]   out_dst;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   k;
        logic [7:0]   s;
        logic [7:0]   t;
        int           c;
    } beat_t;

    beat_t beats[$];
    int    acc_cyc[$];

    fragment_lane_packer #(
        .PW      (128),
        .FW      (32),
        .LANES   (4),
        .TIMEOUT (16)
    ) dut (
        .aclk              (clk),
        .arstn             (arstn),
        .lii_in_p0_tdata   (in_tdata),
        .lii_in_p0_tvalid  (in_tvalid),
        .lii_in_p0_tready  (in_tready),
        .lii_in_p0_src     (in_src),
        .lii_in_p0_dst     (in_dst),
        .lii_out_p0_tdata  (out_tdata),
        .lii_out_p0_tkeep  (out_tkeep),
        .lii_out_p0_tvalid (out_tvalid),
        .lii_out_p0_tready (out_tready),
        .lii_out_p0_src    (out_src),
        .lii_out_p0_dst    (out_dst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (out_tvalid && out_tready)
            beats.push_back('{out_tdata, out_tkeep, out_src, out_dst, cyc});
        if (in_tvalid && in_tready)
            acc_cyc.push_back(cyc);
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [127:0] d,
                            input logic [3:0] k, input logic [7:0] s, input logic [7:0] t);
        chk({tag, "_present"}, 128'(idx < beats.size()), 128'(1));
        if (idx < beats.size()) begin
            chk({tag, "_data"}, beats[idx].d, d);
            chk({tag, "_keep"}, 128'(beats[idx].k), 128'(k));
            chk({tag, "_route"}, 128'({beats[idx].s, beats[idx].t}), 128'({s, t}));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [7:0] s, input logic [7:0] t);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        in_tdata  = {96'hDEAD_BEEF_CAFE_F00D_1234_5678, d};
        in_src    = s;
        in_dst    = t;
        in_tvalid = 1'b1;
        while (!done && n < 100) begin
            @(negedge clk);
            done = in_tready;
            @(posedge clk);
            #1;
            n++;
        end
        in_tvalid = 1'b0;
        if (!done)
            chk("send_accept_bound", 128'(done), 128'(1));
    endtask

    task automatic clear_logs();
        beats.delete();
        acc_cyc.delete();
    endtask

    initial begin
        int  k;
        bit  a;
        in_tdata   = '0;
        in_tvalid  = 1'b0;
        in_src     = '0;
        in_dst     = '0;
        out_tready = 1'b1;

        // Reset state
        #2;
        chk("rst_tvalid", 128'(out_tvalid), 128'(0));
        chk("rst_tdata", out_tdata, 128'(0));
        chk("rst_tkeep", 128'(out_tkeep), 128'(0));
        chk("rst_route", 128'({out_src, out_dst}), 128'(0));
        chk("rst_in_tready", 128'(in_tready), 128'(0));
        @(posedge clk);
        #1;
        arstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 128'(in_tready), 128'(1));
        @(posedge clk);
        #1;

        // Two full words, back to back
        clear_logs();
        for (int i = 0; i < 8; i++)
            send(32'h11 + 32'(i), 8'd1, 8'd2);
        idle(3);
        chk("full_beats", 128'(beats.size()), 128'(2));
        chk_beat("full0", 0, 128'h00000014_00000013_00000012_00000011, 4'hF, 8'd1, 8'd2);
        chk_beat("full1", 1, 128'h00000018_00000017_00000016_00000015, 4'hF, 8'd1, 8'd2);
        if (beats.size() > 0 && acc_cyc.size() > 7) begin
            chk("full_latency", 128'(beats[0].c - acc_cyc[3]), 128'(1));
            chk("full_throughput", 128'(acc_cyc[7] - acc_cyc[0]), 128'(7));
        end

        // Timeout flush of a 3-fragment word
        clear_logs();
        send(32'h21, 8'd1, 8'd2);
        send(32'h22, 8'd1, 8'd2);
        send(32'h23, 8'd1, 8'd2);
        idle(25);
        chk("to_beats", 128'(beats.size()), 128'(1));
        chk_beat("to0", 0, 128'h00000000_00000023_00000022_00000021, 4'h7, 8'd1, 8'd2);
        if (beats.size() > 0 && acc_cyc.size() > 2)
            chk("to_latency", 128'(beats[0].c - acc_cyc[2]), 128'(18));

        // Route change flushes the partial word
        clear_logs();
        send(32'hA1, 8'd1, 8'd2);
        send(32'hB2, 8'd1, 8'd2);
        send(32'hC3, 8'd1, 8'd3);
        idle(25);
        chk("mm_beats", 128'(beats.size()), 128'(2));
        chk_beat("mm0", 0, 128'h00000000_00000000_000000B2_000000A1, 4'h3, 8'd1, 8'd2);
        chk_beat("mm1", 1, 128'h00000000_00000000_00000000_000000C3, 4'h1, 8'd1, 8'd3);
        if (beats.size() > 0 && acc_cyc.size() > 2) begin
            chk("mm_stall", 128'(acc_cyc[2] - acc_cyc[1]), 128'(2));
            chk("mm_flush_time", 128'(beats[0].c - acc_cyc[1]), 128'(2));
        end

        // Output back-pressure for 20 cycles with 10 fragments offered
        clear_logs();
        out_tready = 1'b0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            in_tvalid = (k < 10);
            in_tdata  = {96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5, 32'h40 + 32'(k)};
            in_src    = 8'd1;
            in_dst    = 8'd2;
            @(negedge clk);
            a = in_tvalid && in_tready;
            @(posedge clk);
            #1;
            if (a) k++;
        end
        @(negedge clk);
        chk("bp_accepted", 128'(k), 128'(7));
        chk("bp_in_tready", 128'(in_tready), 128'(0));
        chk("bp_tvalid", 128'(out_tvalid), 128'(1));
        chk("bp_hold_data", out_tdata, 128'h00000043_00000042_00000041_00000040);
        chk("bp_hold_keep", 128'(out_tkeep), 128'(4'hF));
        @(posedge clk);
        #1;
        out_tready = 1'b1;
        for (int i = 0; i < 20 && k < 10; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = {96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5, 32'h40 + 32'(k)};
            @(negedge clk);
            a = in_tready;
            @(posedge clk);
            #1;
            if (a) k++;
        end
        in_tvalid = 1'b0;
        chk("bp_all_accepted", 128'(k), 128'(10));
        idle(25);
        chk("bp_beats", 128'(beats.size()), 128'(3));
        chk_beat("bp0", 0, 128'h00000043_00000042_00000041_00000040, 4'hF, 8'd1, 8'd2);
        chk_beat("bp1", 1, 128'h00000047_00000046_00000045_00000044, 4'hF, 8'd1, 8'd2);
        chk_beat("bp2", 2, 128'h00000000_00000000_00000049_00000048, 4'h3, 8'd1, 8'd2);

        // Accept on the exact cycle the timeout would fire
        clear_logs();
        send(32'h51, 8'd4, 8'd5);
        send(32'h52, 8'd4, 8'd5);
        idle(16);
        send(32'h53, 8'd4, 8'd5);
        chk("tc_no_flush", 128'(beats.size()), 128'(0));
        send(32'h54, 8'd4, 8'd5);
        idle(3);
        chk("tc_beats", 128'(beats.size()), 128'(1));
        chk_beat("tc0", 0, 128'h00000054_00000053_00000052_00000051, 4'hF, 8'd4, 8'd5);
        if (acc_cyc.size() > 2)
            chk("tc_gap", 128'(acc_cyc[2] - acc_cyc[1]), 128'(17));

        // Reset mid-word with a held output beat
        clear_logs();
        out_tready = 1'b0;
        send(32'h61, 8'd1, 8'd2);
        send(32'h62, 8'd1, 8'd2);
        send(32'h63, 8'd1, 8'd2);
        send(32'h64, 8'd1, 8'd2);
        send(32'h65, 8'd1, 8'd2);
        send(32'h66, 8'd1, 8'd2);
        in_tdata  = {96'h0, 32'h99};
        in_tvalid = 1'b1;
        #2;
        arstn = 1'b0;
        #1;
        chk("mr_tvalid", 128'(out_tvalid), 128'(0));
        chk("mr_tdata", out_tdata, 128'(0));
        chk("mr_tkeep", 128'(out_tkeep), 128'(0));
        chk("mr_route", 128'({out_src, out_dst}), 128'(0));
        chk("mr_in_tready", 128'(in_tready), 128'(0));
        idle(2);
        in_tvalid  = 1'b0;
        arstn      = 1'b1;
        out_tready = 1'b1;
        clear_logs();
        idle(25);
        chk("mr_no_beat", 128'(beats.size()), 128'(0));
        send(32'h71, 8'd1, 8'd2);
        send(32'h72, 8'd1, 8'd2);
        send(32'h73, 8'd1, 8'd2);
        send(32'h74, 8'd1, 8'd2);
        idle(3);
        chk("mr_beats", 128'(beats.size()), 128'(1));
        chk_beat("mr0", 0, 128'h00000074_00000073_00000072_00000071, 4'hF, 8'd1, 8'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
